// File: rtl/bch_dec_arbiter.sv
// ============================================================
// Module  : bch_dec_arbiter (with bch_decoder)
// Brief   : Round-robin arbiter sharing one BCH(15,7) DEC decoder.
// Revision: 1.0
// ============================================================
`default_nettype none

module bch_decoder (
  input  logic [14:0] i_word,
  output logic [14:0] o_codeword,
  output logic [6:0]  o_message,
  output logic        o_detect
);
  // g(x) = x^8 + x^7 + x^6 + x^4 + 1
  localparam logic [8:0] C_GEN = 9'h1D1;

  logic [7:0]  w_syn;
  logic [14:0] w_err;

  function automatic logic [7:0] f_syndrome(input logic [14:0] w);
    logic [8:0] r;
    r = '0;
    for (int k = 14; k >= 0; k--) begin
      r = {r[7:0], w[k]};
      if (r[8]) r = r ^ C_GEN;
    end
    return r[7:0];
  endfunction

  // Syndromes of all weight-1 and weight-2 patterns are distinct, so a match
  // identifies the error uniquely; anything else is passed through unchanged.
  always_comb begin
    w_syn = f_syndrome(i_word);
    w_err = '0;
    for (int i = 0; i < 15; i++) begin
      if (w_syn == f_syndrome(15'(1) << i)) w_err = 15'(1) << i;
      for (int j = i + 1; j < 15; j++) begin
        if (w_syn == (f_syndrome(15'(1) << i) ^ f_syndrome(15'(1) << j)))
          w_err = (15'(1) << i) | (15'(1) << j);
      end
    end
  end

  assign o_codeword = i_word ^ w_err;
  assign o_message  = o_codeword[14:8];
  assign o_detect   = |w_syn;
endmodule

module bch_dec_arbiter #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 16,
  localparam int C_IDX_W = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [15*NREQ-1:0]   req_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [C_IDX_W-1:0]   rsp_src,
  output logic [14:0]          rsp_codeword,
  output logic [6:0]           rsp_message,
  output logic                 rsp_detect,
  input  logic                 clr_cnt,
  output logic [CNT_W-1:0]     cnt_total,
  output logic [CNT_W-1:0]     cnt_detect
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DEC  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [C_IDX_W-1:0]   r_ptr, r_src_lat, w_grant_idx;
  logic                 w_grant_any, w_req_hs, w_rsp_hs;
  logic [14:0]          r_word;
  logic [14:0]          w_dec_codeword;
  logic [6:0]           w_dec_message;
  logic                 w_dec_detect;
  logic [CNT_W-1:0]     r_cnt_total, r_cnt_detect;

  bch_decoder u_dec (
    .i_word     (r_word),
    .o_codeword (w_dec_codeword),
    .o_message  (w_dec_message),
    .o_detect   (w_dec_detect)
  );

  // Scan from lowest priority to highest so the closest requester to r_ptr wins.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      int v_idx;
      v_idx = (int'(r_ptr) + off) % NREQ;
      if (req_valid[v_idx]) begin
        w_grant_any = 1'b1;
        w_grant_idx = C_IDX_W'(v_idx);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    rsp_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant_any && !rst) begin
          req_ready   = NREQ'(1) << w_grant_idx;
          w_state_nxt = S_DEC;
        end
      end
      S_DEC:  w_state_nxt = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_req_hs = (r_state == S_IDLE) && w_grant_any;
  assign w_rsp_hs = rsp_valid && rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_word       <= '0;
      r_src_lat    <= '0;
      rsp_src      <= '0;
      rsp_codeword <= '0;
      rsp_message  <= '0;
      rsp_detect   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_req_hs) begin
        r_word    <= req_data[15*w_grant_idx +: 15];
        r_src_lat <= w_grant_idx;
        r_ptr     <= (w_grant_idx == C_IDX_W'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;
      end
      if (r_state == S_DEC) begin
        rsp_codeword <= w_dec_codeword;
        rsp_message  <= w_dec_message;
        rsp_detect   <= w_dec_detect;
        rsp_src      <= r_src_lat;
      end
    end
  end

  // Saturating statistics; a clear overrides a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_total  <= '0;
      r_cnt_detect <= '0;
    end else if (clr_cnt) begin
      r_cnt_total  <= '0;
      r_cnt_detect <= '0;
    end else if (w_rsp_hs) begin
      if (r_cnt_total != '1) r_cnt_total <= r_cnt_total + 1'b1;
      if (rsp_detect && (r_cnt_detect != '1)) r_cnt_detect <= r_cnt_detect + 1'b1;
    end
  end

  assign cnt_total  = r_cnt_total;
  assign cnt_detect = r_cnt_detect;
endmodule

`default_nettype wire

// File: tb/tb_bch_dec_arbiter.sv
// ============================================================
// Module  : tb_bch_dec_arbiter
// Brief   : Directed self-checking bench for bch_dec_arbiter.
// Revision: 1.0
// ============================================================
`default_nettype none

module tb_bch_dec_arbiter;
  localparam logic [14:0] C_CLEAN    = 15'b110100010000001;
  localparam logic [14:0] C_ERR1     = 15'b011011100001110;
  localparam logic [14:0] C_ERR1_FIX = 15'b011011100001010;
  localparam logic [14:0] C_ERR2     = 15'b010100010000000;
  localparam logic [14:0] C_ERR3     = 15'b001100010000001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [59:0] req_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_src;
  logic [14:0] rsp_codeword;
  logic [6:0]  rsp_message;
  logic        rsp_detect;
  logic        clr_cnt = 1'b0;
  logic [15:0] cnt_total, cnt_detect;

  int checks = 0;
  int failures = 0;

  bch_dec_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_src(rsp_src), .rsp_codeword(rsp_codeword), .rsp_message(rsp_message),
    .rsp_detect(rsp_detect), .clr_cnt(clr_cnt), .cnt_total(cnt_total),
    .cnt_detect(cnt_detect)
  );

  always #5 clk = ~clk;

  task automatic issue(input int idx, input logic [14:0] w);
    req_data[15*idx +: 15] = w;
    req_valid = 4'(1) << idx;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'b1111;
    req_data = {4{C_CLEAN}};
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (cnt_total !== 16'd0 || cnt_detect !== 16'd0) begin failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", cnt_total, cnt_detect); end
    checks++; if (rsp_src !== 2'd0 || rsp_codeword !== 15'd0 || rsp_message !== 7'd0 || rsp_detect !== 1'b0) begin
      failures++; $display("FAIL reset_outputs src=%0d cw=%b msg=%b det=%b exp=all zero", rsp_src, rsp_codeword, rsp_message, rsp_detect); end
    req_valid = '0;
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL idle_no_req got=%b exp=0000", req_ready); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL idle_stays got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_clean();
    rsp_ready = 1'b1;
    issue(0, C_CLEAN);
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL clean_grant got=%b exp=0001", req_ready); end
    @(negedge clk); req_valid = '0; #1;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin failures++; $display("FAIL clean_dec valid=%b ready=%b exp=0/0000", rsp_valid, req_ready); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL clean_latency got=%b exp=1", rsp_valid); end
    checks++; if (rsp_message !== 7'b1101000 || rsp_detect !== 1'b0 || rsp_src !== 2'd0 || rsp_codeword !== C_CLEAN) begin
      failures++; $display("FAIL clean_result msg=%b det=%b src=%0d cw=%b exp=1101000/0/0/%b", rsp_message, rsp_detect, rsp_src, rsp_codeword, C_CLEAN); end
    @(negedge clk); #1;
    checks++; if (cnt_total !== 16'd1 || cnt_detect !== 16'd0) begin failures++; $display("FAIL clean_count got=%0d/%0d exp=1/0", cnt_total, cnt_detect); end
  endtask

  task automatic test_single_error();
    issue(2, C_ERR1);
    #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL err1_grant got=%b exp=0100", req_ready); end
    @(negedge clk); req_valid = '0;
    @(negedge clk); #1;
    checks++; if (rsp_message !== 7'b0110111 || rsp_detect !== 1'b1 || rsp_src !== 2'd2 || rsp_codeword !== C_ERR1_FIX) begin
      failures++; $display("FAIL err1_result msg=%b det=%b src=%0d cw=%b exp=0110111/1/2/%b", rsp_message, rsp_detect, rsp_src, rsp_codeword, C_ERR1_FIX); end
    @(negedge clk); #1;
    checks++; if (cnt_total !== 16'd2 || cnt_detect !== 16'd1) begin failures++; $display("FAIL err1_count got=%0d/%0d exp=2/1", cnt_total, cnt_detect); end
  endtask

  task automatic test_double_error();
    issue(3, C_ERR2);
    @(negedge clk); req_valid = '0;
    @(negedge clk); #1;
    checks++; if (rsp_codeword !== C_CLEAN || rsp_message !== 7'b1101000 || rsp_detect !== 1'b1 || rsp_src !== 2'd3) begin
      failures++; $display("FAIL err2_result cw=%b msg=%b det=%b src=%0d exp=%b/1101000/1/3", rsp_codeword, rsp_message, rsp_detect, rsp_src, C_CLEAN); end
    @(negedge clk); #1;
    checks++; if (cnt_total !== 16'd3 || cnt_detect !== 16'd2) begin failures++; $display("FAIL err2_count got=%0d/%0d exp=3/2", cnt_total, cnt_detect); end
  endtask

  task automatic test_round_robin();
    req_data = {4{C_CLEAN}};
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    for (int c = 0; c < 13; c++) begin
      logic [3:0] v_exp;
      #1;
      v_exp = (c % 3 == 0) ? (4'(1) << ((c / 3) % 4)) : 4'b0000;
      checks++; if (req_ready !== v_exp) begin failures++; $display("FAIL rr_ready cycle=%0d got=%b exp=%b", c, req_ready, v_exp); end
      if (c % 3 == 2) begin
        checks++; if (rsp_valid !== 1'b1 || rsp_src !== 2'((c / 3) % 4)) begin
          failures++; $display("FAIL rr_src cycle=%0d valid=%b src=%0d exp=1/%0d", c, rsp_valid, rsp_src, (c / 3) % 4); end
      end
      @(negedge clk);
    end
    req_valid = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (cnt_total !== 16'd8 || cnt_detect !== 16'd2) begin failures++; $display("FAIL rr_count got=%0d/%0d exp=8/2", cnt_total, cnt_detect); end
  endtask

  task automatic test_stall();
    rsp_ready = 1'b0;
    issue(1, C_ERR1);
    @(negedge clk); req_valid = 4'b1111; #1;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL stall_dec_ready got=%b exp=0000", req_ready); end
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_codeword !== C_ERR1_FIX || rsp_message !== 7'b0110111 || rsp_detect !== 1'b1 || rsp_src !== 2'd1) begin
        failures++; $display("FAIL stall_hold k=%0d valid=%b cw=%b msg=%b det=%b src=%0d", k, rsp_valid, rsp_codeword, rsp_message, rsp_detect, rsp_src); end
      checks++; if (req_ready !== 4'b0000 || cnt_total !== 16'd8) begin
        failures++; $display("FAIL stall_side k=%0d ready=%b total=%0d exp=0000/8", k, req_ready, cnt_total); end
      @(negedge clk);
    end
    rsp_ready = 1'b1; #1;
    checks++; if (rsp_valid !== 1'b1 || req_ready !== 4'b0000) begin failures++; $display("FAIL stall_release valid=%b ready=%b exp=1/0000", rsp_valid, req_ready); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0100) begin failures++; $display("FAIL stall_after valid=%b ready=%b exp=0/0100", rsp_valid, req_ready); end
    checks++; if (cnt_total !== 16'd9 || cnt_detect !== 16'd3) begin failures++; $display("FAIL stall_count got=%0d/%0d exp=9/3", cnt_total, cnt_detect); end
    req_valid = '0;
  endtask

  task automatic test_saturate();
    @(negedge clk);
    force dut.r_cnt_total = 16'hFFFF;
    #1;
    release dut.r_cnt_total;
    #1;
    checks++; if (cnt_total !== 16'hFFFF) begin failures++; $display("FAIL sat_preload got=%h exp=ffff", cnt_total); end
    rsp_ready = 1'b1;
    issue(2, C_CLEAN);
    @(negedge clk); req_valid = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (cnt_total !== 16'hFFFF || cnt_detect !== 16'd3) begin failures++; $display("FAIL sat_hold got=%h/%0d exp=ffff/3", cnt_total, cnt_detect); end
    issue(3, C_ERR3);
    @(negedge clk); req_valid = '0;
    @(negedge clk); clr_cnt = 1'b1; #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_detect !== 1'b1) begin failures++; $display("FAIL err3_detect valid=%b det=%b exp=1/1", rsp_valid, rsp_detect); end
    @(negedge clk); clr_cnt = 1'b0; #1;
    checks++; if (cnt_total !== 16'd0 || cnt_detect !== 16'd0 || rsp_valid !== 1'b0) begin
      failures++; $display("FAIL clr_wins got=%0d/%0d valid=%b exp=0/0/0", cnt_total, cnt_detect, rsp_valid); end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    issue(1, C_CLEAN);
    @(negedge clk); req_valid = '0;
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_src !== 2'd1) begin failures++; $display("FAIL mid_resp valid=%b src=%0d exp=1/1", rsp_valid, rsp_src); end
    #1 rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_message !== 7'd0 || rsp_codeword !== 15'd0) begin
      failures++; $display("FAIL mid_async valid=%b msg=%b cw=%b exp=0/0/0", rsp_valid, rsp_message, rsp_codeword); end
    checks++; if (cnt_total !== 16'd0 || cnt_detect !== 16'd0) begin failures++; $display("FAIL mid_count got=%0d/%0d exp=0/0", cnt_total, cnt_detect); end
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL mid_ptr got=%b exp=0001", req_ready); end
    @(negedge clk); req_valid = '0;
    @(negedge clk); #1;
    checks++; if (rsp_src !== 2'd0 || rsp_valid !== 1'b1) begin failures++; $display("FAIL mid_src got=%0d valid=%b exp=0/1", rsp_src, rsp_valid); end
    @(negedge clk); #1;
    checks++; if (cnt_total !== 16'd1) begin failures++; $display("FAIL mid_after_count got=%0d exp=1", cnt_total); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_error();
    test_double_error();
    test_round_robin();
    test_stall();
    test_saturate();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/bch_dec_arbiter.md
BCH_DEC_ARBITER -- requirements
Module: bch_dec_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters; legal range 2..8.
REQ-002 Parameter CNT_W, default 16, width of the statistics counters.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req_valid  input  NREQ  per-requester request valid.
REQ-006 req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
REQ-007 req_data  input  15*NREQ  packed received words; requester i occupies bits [15*i+14:15*i].
REQ-008 rsp_valid  output  1  decoded result valid.
REQ-009 rsp_ready  input  1  consumer accepts the result.
REQ-010 rsp_src  output  max(1,clog2(NREQ))  index of the requester that owns the result.
REQ-011 rsp_codeword  output  15  corrected codeword.
REQ-012 rsp_message  output  7  decoded message, codeword bits [14:8].
REQ-013 rsp_detect  output  1  nonzero syndrome, covering both corrected and uncorrectable words.
REQ-014 clr_cnt  input  1  synchronous clear of both counters.
REQ-015 cnt_total  output  CNT_W  number of completed responses.
REQ-016 cnt_detect  output  CNT_W  number of completed responses with rsp_detect=1.

Function
REQ-017 The block shall instantiate exactly one existing bch_decoder (15,7 DEC) and share it among all requesters.
REQ-018 The FSM shall have three states: IDLE, DEC and RESP.
REQ-019 In IDLE with any req_valid high, the block shall assert req_ready for one granted requester only, combinationally, in that same cycle.
REQ-020 On that handshake, the block shall latch req_data of the granted requester and its index, then enter DEC.
REQ-021 In IDLE with no req_valid high, req_ready shall be all-zero and the state shall remain IDLE.
REQ-022 Arbitration shall be round-robin: after a grant to i, priority order shall start at (i+1) mod NREQ.
REQ-023 Round-robin pointer wrap: a grant to NREQ-1 shall give next priority to requester 0.
REQ-024 In DEC, the block shall drive the latched word into the decoder and register codeword, message, detect and source into the output registers, then enter RESP.
REQ-025 In RESP, rsp_valid shall be 1 and the output registers shall hold stable until rsp_ready=1.
REQ-026 On the rsp_valid&rsp_ready handshake, the block shall return to IDLE; no new grant shall be issued in that cycle.
REQ-027 Latency: a request accepted in cycle T shall have rsp_valid=1 from cycle T+2.
REQ-028 Peak throughput shall be one result per 3 cycles when rsp_ready is held high.
REQ-029 req_ready shall be 0 in DEC and in RESP.
REQ-030 A requester deasserting req_valid in IDLE before a grant shall have no effect on state.
REQ-031 On each response handshake, cnt_total shall increment by 1.
REQ-032 On each response handshake with rsp_detect=1, cnt_detect shall increment by 1.
REQ-033 Both counters shall saturate at all-ones and shall not wrap.
REQ-034 When clr_cnt and an increment occur in the same cycle, the clear shall win and both counters shall become 0.
REQ-035 rsp_detect and rsp_message shall equal the bch_decoder outputs for the latched word, bit-exact.

Reset
REQ-036 When rst is asserted, state shall become IDLE and rsp_valid, req_ready, rsp_src, rsp_codeword, rsp_message, rsp_detect, cnt_total and cnt_detect shall all be 0, asynchronously.
REQ-037 After reset, the round-robin pointer shall give requester 0 top priority.
REQ-038 Reset mid-operation (in DEC or RESP) shall discard the in-flight word and shall not count it.
REQ-039 The first grant after reset deassertion shall be no earlier than the first rising clk edge.

Verification
REQ-040 Requester 0 sends 15'b110100010000001, rsp_ready=1 -> at T+2: rsp_message=7'b1101000, rsp_detect=0, rsp_src=0, cnt_total=1.
REQ-041 Requester 2 sends 15'b011011100001110 -> rsp_message=7'b0110111, rsp_detect=1, rsp_src=2, cnt_detect=1.
REQ-042 All 4 requesters hold valid continuously -> grants in order 0,1,2,3,0; each requester's req_ready pulses once per 12 cycles.
REQ-043 rsp_ready held low for 5 cycles in RESP -> outputs stable for the whole stall, req_ready=0, no counter change; the cycle after release is IDLE.
REQ-044 Preload cnt_total to all-ones by forcing -> further responses leave it at all-ones; clr_cnt in a handshake cycle -> both counters become 0.
REQ-045 rst asserted while in RESP -> rsp_valid drops to 0 without waiting for clk, counters unchanged by the aborted word, next grant goes to requester 0.
